uart_rx_fifo: RTL

//  Byte FIFO between the UART receiver and the peripheral read mux. Drains uart_rx through
//  its valid/read handshake and buffers bytes until the CPU pops them with a bus read of the

---
 rtl/tinyqv_peri_pkg.sv | 43 ++++
 rtl/uart_rx_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tinyqv_peri_pkg.sv
// Shared peripheral definitions for the TinyQV UART slice.
//  - Peripheral select codes for the UART data and status registers.
//  - Bit positions inside the UART status word and the status-write flush bit.
//  - Ingress handshake state type used by uart_rx_fifo.
//  - Helper that packs the status word the read mux returns.
package tinyqv_peri_pkg;

  // Peripheral select codes on the TinyQV peripheral bus
  localparam logic [3:0] PERI_UART        = 4'h2;
  localparam logic [3:0] PERI_UART_STATUS = 4'h3;

  // UART status word bit positions (read side)
  localparam int unsigned UART_STATUS_TX_BUSY    = 0;
  localparam int unsigned UART_STATUS_RX_VALID   = 1;
  localparam int unsigned UART_STATUS_RX_OVERRUN = 2;
  localparam int unsigned UART_STATUS_RX_FULL    = 3;

  // Writing the status register with this bit set empties the receive FIFO
  localparam int unsigned UART_STATUS_FLUSH_BIT  = 2;

  // Ingress side of the uart_rx handshake: after every acknowledge the FIFO
  // sits out one cycle so the receiver's registered valid has time to drop.
  typedef enum logic {
    ING_OPEN = 1'b0,
    ING_HOLD = 1'b1
  } ingress_state_t;

  function automatic logic [7:0] uart_status_word(
    input logic tx_busy,
    input logic rx_valid,
    input logic rx_overrun,
    input logic rx_full
  );
    logic [7:0] w;
    w = '0;
    w[UART_STATUS_TX_BUSY]    = tx_busy;
    w[UART_STATUS_RX_VALID]   = rx_valid;
    w[UART_STATUS_RX_OVERRUN] = rx_overrun;
    w[UART_STATUS_RX_FULL]    = rx_full;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between uart_rx and the peripheral read mux.
// Drains uart_rx through its valid/read handshake, buffers bytes in a small
// flop array and presents the head byte combinationally for a single-cycle
// bus read. Produces RTS back-pressure and a level interrupt from fill level.
//
// Ports
//  clk          system clock
//  rst          synchronous reset, active high
//  rx_valid     uart_rx holds an unread byte
//  rx_data      uart_rx byte, stable while rx_valid
//  rx_read      one-cycle acknowledge back to uart_rx
//  pop          bus read of the UART data address
//  flush        discard all entries
//  rd_data      head byte, 8'h00 when empty
//  empty        count == 0
//  full         count == DEPTH
//  count        current fill level
//  overrun      sticky: a byte was offered while full
//  clr_overrun  clears overrun
//  rts          1 = peer must stop sending (registered)
//  irq_level    interrupt request level
module uart_rx_fifo
  import tinyqv_peri_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_W      = 3,
  parameter int unsigned IRQ_THRESH = 1,
  parameter int unsigned RTS_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_read,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             rts,
  output logic             irq_level
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W:0] DEPTH_LVL = CNT_W'(DEPTH);
  localparam logic [PTR_W:0] RTS_LVL   = CNT_W'(DEPTH - RTS_MARGIN);
  localparam logic [PTR_W:0] IRQ_LVL   = CNT_W'(IRQ_THRESH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             overrun_q;
  logic             rts_q;

  ingress_state_t   ing_state_q;
  ingress_state_t   ing_state_d;
  logic             hold;

  logic             push;
  logic             pop_ok;

  // Status derived from the registered count; full deliberately ignores a
  // same-cycle pop so a slot freed this cycle is only reusable next cycle.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_LVL);

  // Flush wins over both ends of the queue, including the uart_rx ack.
  assign push   = rx_valid && !full && !hold && !flush;
  assign pop_ok = pop && !empty && !flush;

  // ---------------------------------------------------------------------
  // Ingress handshake FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ing_state_q <= ING_OPEN;
    end else begin
      ing_state_q <= ing_state_d;
    end
  end

  always_comb begin
    ing_state_d = ING_OPEN;
    if (push) begin
      ing_state_d = ING_HOLD;
    end
  end

  always_comb begin
    hold    = (ing_state_q == ING_HOLD);
    rx_read = push;
  end

  // ---------------------------------------------------------------------
  // Storage: flop array, no reset needed because rd_data is gated by empty
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------
  // Pointers and fill level; pointers wrap naturally at power-of-two DEPTH
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky overrun: a byte offered while full (outside the hold cycle).
  // Setting takes priority over a simultaneous clear.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (rx_valid && full && !hold) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  // RTS follows the fill level one cycle late
  always_ff @(posedge clk) begin
    if (rst) begin
      rts_q <= 1'b0;
    end else begin
      rts_q <= (count_q >= RTS_LVL);
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign rd_data   = empty ? '0 : mem[rd_ptr];
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign rts       = rts_q;
  assign irq_level = (count_q >= IRQ_LVL);

endmodule
